// File: rtl/uart_pkg.sv
// Shared types and bit-timing helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int DEFAULT_DATA_WIDTH   = 8;

    // Counter value at which a bit is sampled, relative to the start edge modulo one bit.
    function automatic int half_bit_count(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    // Terminal value of the bit-period counter before it wraps to zero.
    function automatic int full_bit_count(input int clks_per_bit);
        return clks_per_bit - 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: count-based sampling from the start edge, LSB-first
// word recovery, and a single-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT_P = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH_P   = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_i,
    output logic [DATA_WIDTH_P-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    frame_err_o,
    output logic                    overrun_o
);

    localparam int CW     = $clog2(CLKS_PER_BIT_P);
    localparam int IW     = (DATA_WIDTH_P > 1) ? $clog2(DATA_WIDTH_P) : 1;
    localparam int HALF_C = half_bit_count(CLKS_PER_BIT_P);
    localparam int WRAP_C = full_bit_count(CLKS_PER_BIT_P);

    uart_rx_state_e          state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH_P-1:0] shift_q, shift_d;
    logic                    rx_prev_q, rx_prev_d;
    logic [DATA_WIDTH_P-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic sample_point;
    assign sample_point = (cnt_q == CW'(HALF_C));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rx_prev_d   = rx_i;
        // cnt tracks (cycles since start edge) mod CLKS_PER_BIT_P
        cnt_d       = (cnt_q == CW'(WRAP_C)) ? '0 : cnt_q + 1'b1;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_i) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (sample_point) begin
                    idx_d   = '0;
                    state_d = rx_i ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_point) begin
                    shift_d = {rx_i, shift_q[DATA_WIDTH_P-1:1]};
                    if (idx_q == IW'(DATA_WIDTH_P - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_point) begin
                    if (rx_i) begin
                        state_d = IDLE;
                        if (valid_q && !ready_i) begin
                            overrun_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_prev_q   <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_prev_q   <= rx_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 8 data bits.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    int checks   = 0;
    int pass_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    uart_rx #(.CLKS_PER_BIT_P(16), .DATA_WIDTH_P(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr)  ovr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Start bit plus data bits; returns at t=144 where the stop bit begins.
    task automatic send_data(input logic [7:0] d);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(16);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        tick(3);

        // Clean frame 0xA5
        send_data(8'hA5);
        rx = 1'b1;
        tick(8);
        check("a5_pre_valid", 32'(valid), 32'd0);
        tick(1);
        check("a5_valid", 32'(valid), 32'd1);
        check("a5_data", 32'(data), 32'hA5);
        tick(1);
        check("a5_accepted", 32'(valid), 32'd0);
        tick(10);
        check("a5_no_err", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // Glitch on the start bit
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(5);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        tick(20);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        send_data(8'h3C);
        rx = 1'b1;
        tick(9);
        check("3c_valid", 32'(valid), 32'd1);
        check("3c_data", 32'(data), 32'h3C);
        tick(16);

        // Framing error with the line held low
        send_data(8'h3C);
        tick(8);
        check("fe_pre", 32'(ferr), 32'd0);
        tick(1);
        check("fe_pulse", 32'(ferr), 32'd1);
        check("fe_valid", 32'(valid), 32'd0);
        tick(1);
        check("fe_one_cycle", 32'(ferr), 32'd0);
        tick(30);
        check("fe_break", 32'(dut.state_q), 32'(BREAK));
        check("fe_no_valid", 32'(valid), 32'd0);
        rx = 1'b1;
        tick(2);
        check("fe_idle", 32'(dut.state_q), 32'(IDLE));
        check("fe_count", 32'(ferr_cnt), 32'd1);
        tick(5);

        // Backpressure: second word overruns
        ready = 1'b0;
        send_data(8'h11);
        rx = 1'b1;
        tick(9);
        check("bp_valid1", 32'(valid), 32'd1);
        check("bp_data1", 32'(data), 32'h11);
        tick(7);
        send_data(8'h22);
        rx = 1'b1;
        tick(8);
        check("bp_ovr_pre", 32'(ovr), 32'd0);
        tick(1);
        check("bp_ovr", 32'(ovr), 32'd1);
        check("bp_data_hold", 32'(data), 32'h11);
        check("bp_valid_hold", 32'(valid), 32'd1);
        tick(1);
        check("bp_ovr_once", 32'(ovr), 32'd0);
        tick(6);
        ready = 1'b1;
        tick(1);
        check("bp_accepted", 32'(valid), 32'd0);
        check("bp_ovr_count", 32'(ovr_cnt), 32'd1);
        tick(5);

        // Accept and load in the same cycle
        ready = 1'b0;
        send_data(8'h11);
        rx = 1'b1;
        tick(16);
        send_data(8'h22);
        rx = 1'b1;
        tick(8);
        ready = 1'b1;
        tick(1);
        check("col_data", 32'(data), 32'h22);
        check("col_valid", 32'(valid), 32'd1);
        check("col_no_ovr", 32'(ovr), 32'd0);
        tick(1);
        check("col_accepted", 32'(valid), 32'd0);
        check("col_ovr_count", 32'(ovr_cnt), 32'd1);
        tick(10);

        // Reset in the middle of a frame while a word is held
        ready = 1'b0;
        send_data(8'h77);
        rx = 1'b1;
        tick(9);
        check("rm_held", 32'(valid), 32'd1);
        tick(7);
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(56);
        #2;
        rst = 1'b1;
        #1;
        check("rm_valid", 32'(valid), 32'd0);
        check("rm_data", 32'(data), 32'h00);
        check("rm_state", 32'(dut.state_q), 32'(IDLE));
        tick(2);
        rst = 1'b0;
        ready = 1'b1;
        tick(4);
        send_data(8'h5A);
        rx = 1'b1;
        tick(8);
        check("5a_pre", 32'(valid), 32'd0);
        tick(1);
        check("5a_valid", 32'(valid), 32'd1);
        check("5a_data", 32'(data), 32'h5A);
        tick(10);

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
